// File: rtl/color_sensor_pkg.sv
// Shared constants and types for the colour-sensor front end and its consumer.
// Defaults assume a 100 MHz system clock.
package color_sensor_pkg;

    localparam int unsigned CLK_HZ        = 100_000_000;
    localparam int unsigned SETTLE_CYCLES = 10_000;
    localparam int unsigned WINDOW_CYCLES = 1_000_000;
    localparam int unsigned FREQ_W        = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [1:0] RED   = 2'd0;
    localparam logic [1:0] GREEN = 2'd1;
    localparam logic [1:0] BLUE  = 2'd2;
    localparam logic [1:0] NONE  = 2'd3;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input plus a one-cycle rising-edge
// pulse taken from the synchronized side.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

endmodule

// File: rtl/color_freq_counter.sv
// Gated rising-edge counter for one colour-filter measurement: settle, count
// over a fixed window, then hold the result with a done handshake.
module color_freq_counter #(
    parameter int unsigned SETTLE_CYCLES = color_sensor_pkg::SETTLE_CYCLES,
    parameter int unsigned WINDOW_CYCLES = color_sensor_pkg::WINDOW_CYCLES,
    parameter int unsigned FREQ_W        = color_sensor_pkg::FREQ_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              colorsignal,
    input  logic              enable,
    output logic              done_count,
    output logic [FREQ_W-1:0] freq,
    output logic              overflow
);

    import color_sensor_pkg::*;

    localparam int unsigned TIMER_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

    // SETTLE exits when the timer reaches SETTLE_CYCLES, so done lands at k+1+SETTLE+WINDOW.
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES);
    localparam logic [TIMER_W-1:0] WINDOW_LAST = TIMER_W'(WINDOW_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETTLE = SETTLE;
    localparam logic [1:0] ST_COUNT  = COUNT;
    localparam logic [1:0] ST_DONE   = DONE;

    logic [1:0]         state;
    logic [TIMER_W-1:0] timer;
    logic [FREQ_W-1:0]  acc;
    logic               sticky;
    logic               rise;
    logic [FREQ_W-1:0]  acc_next;
    logic               sticky_next;

    sync_edge_detect u_sync (
        .clk  (clock),
        .rst  (reset),
        .din  (colorsignal),
        .rise (rise)
    );

    // Saturating accumulate; an edge lost to saturation marks the window as overflowed.
    always_comb begin
        acc_next    = acc;
        sticky_next = sticky;
        if (rise) begin
            if (acc == '1) begin
                sticky_next = 1'b1;
            end else begin
                acc_next = acc + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            acc        <= '0;
            sticky     <= 1'b0;
            freq       <= '0;
            overflow   <= 1'b0;
            done_count <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state  <= ST_SETTLE;
                        timer  <= '0;
                        acc    <= '0;
                        sticky <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (timer == SETTLE_LAST) begin
                        state <= ST_COUNT;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (timer == WINDOW_LAST) begin
                        freq       <= acc_next;
                        overflow   <= sticky_next;
                        done_count <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        acc    <= acc_next;
                        sticky <= sticky_next;
                        timer  <= timer + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        done_count <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_color_freq_counter.sv
// Directed bench for color_freq_counter: a short-window instance driven by a
// periodic generator and a 4-bit, long-settle instance driven by explicit pulses.
module tb_color_freq_counter;

    typedef struct {
        int unsigned f;
        int unsigned o;
    } result_t;

    logic        clock;
    logic        reset;
    logic        cs;
    logic        en;
    logic        done;
    logic [19:0] freq;
    logic        ovf;
    logic        cs2;
    logic        en2;
    logic        done2;
    logic [3:0]  freq2;
    logic        ovf2;

    int unsigned period;
    int unsigned checks;
    int unsigned failures;
    result_t     sb[$];

    color_freq_counter #(.SETTLE_CYCLES(4), .WINDOW_CYCLES(100), .FREQ_W(20)) dut (
        .clock       (clock),
        .reset       (reset),
        .colorsignal (cs),
        .enable      (en),
        .done_count  (done),
        .freq        (freq),
        .overflow    (ovf)
    );

    color_freq_counter #(.SETTLE_CYCLES(20), .WINDOW_CYCLES(100), .FREQ_W(4)) dut2 (
        .clock       (clock),
        .reset       (reset),
        .colorsignal (cs2),
        .enable      (en2),
        .done_count  (done2),
        .freq        (freq2),
        .overflow    (ovf2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Square wave with a run-time period in clock cycles; period 0 holds the pin low.
    initial begin
        int unsigned cnt;
        cnt = 0;
        cs  = 1'b0;
        forever begin
            @(negedge clock);
            #2;
            if (period == 0) begin
                cs  = 1'b0;
                cnt = 0;
            end else begin
                cnt = cnt + 1;
                if (cnt >= period) cnt = 0;
                cs = (cnt < period / 2);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int unsigned f, input int unsigned o);
        result_t r;
        r.f = f;
        r.o = o;
        sb.push_back(r);
    endtask

    // Called at #1 after edge k+elapsed; waits for done and checks latency/result.
    task automatic wait_result(input string tag, input int unsigned elapsed, input int unsigned exp_lat,
                               input logic inst2);
        int unsigned n;
        logic        d;
        result_t     r;
        n = elapsed;
        d = inst2 ? done2 : done;
        while (!d && n < 400) begin
            @(posedge clock);
            #1;
            n++;
            d = inst2 ? done2 : done;
        end
        check({tag, "_latency"}, n, exp_lat);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 1, 0);
        end else begin
            r = sb.pop_front();
            check({tag, "_freq"}, inst2 ? 32'(freq2) : 32'(freq), r.f);
            check({tag, "_ovf"}, inst2 ? 32'(ovf2) : 32'(ovf), r.o);
        end
    endtask

    // Request on the main DUT, check result, hold two cycles, drop enable for one edge.
    task automatic measure(input string tag, input int unsigned p, input int unsigned exp_f);
        @(negedge clock);
        period = p;
        en     = 1'b1;
        push(exp_f, 0);
        @(posedge clock);
        #1;
        wait_result(tag, 0, 105, 1'b0);
        repeat (2) begin
            @(posedge clock);
            #1;
            check({tag, "_done_held"}, 32'(done), 1);
        end
        @(negedge clock);
        en = 1'b0;
        @(posedge clock);
        #1;
        check({tag, "_done_drop"}, 32'(done), 0);
    endtask

    task automatic pulses(input int unsigned n);
        repeat (n) begin
            cs2 = 1'b1;
            repeat (2) begin @(posedge clock); #1; end
            cs2 = 1'b0;
            repeat (2) begin @(posedge clock); #1; end
        end
    endtask

    task automatic drop2(input string tag);
        @(negedge clock);
        en2 = 1'b0;
        @(posedge clock);
        #1;
        check({tag, "_done_drop"}, 32'(done2), 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        period   = 0;
        reset    = 1'b1;
        en       = 1'b0;
        en2      = 1'b0;
        cs2      = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_done", 32'(done), 0);
        check("rst_freq", 32'(freq), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_done2", 32'(done2), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Basic measurement, period 10.
        measure("p10", 10, 10);

        // Abort mid-COUNT keeps the previous result.
        begin
            logic saw;
            @(negedge clock);
            period = 10;
            en     = 1'b1;
            @(posedge clock);
            repeat (55) @(posedge clock);
            @(negedge clock);
            en  = 1'b0;
            saw = 1'b0;
            repeat (120) begin
                @(posedge clock);
                #1;
                if (done) saw = 1'b1;
            end
            check("abort_no_done", 32'(saw), 0);
            check("abort_freq_kept", 32'(freq), 10);
            check("abort_ovf_kept", 32'(ovf), 0);
        end
        measure("after_abort", 20, 5);

        // Back-to-back requests with a one-cycle enable gap.
        measure("b2b_10", 10, 10);
        measure("b2b_20", 20, 5);
        measure("b2b_25", 25, 4);
        measure("b2b_50", 50, 2);

        // Edges only during SETTLE are ignored.
        @(negedge clock);
        en2 = 1'b1;
        push(0, 0);
        @(posedge clock);
        #1;
        pulses(5);
        wait_result("settle_only", 20, 121, 1'b1);
        drop2("settle_only");

        // Saturation at 4 bits, then a clean small count.
        @(negedge clock);
        en2 = 1'b1;
        push(15, 1);
        @(posedge clock);
        #1;
        repeat (24) begin @(posedge clock); #1; end
        pulses(20);
        wait_result("saturate", 104, 121, 1'b1);
        drop2("saturate");

        @(negedge clock);
        en2 = 1'b1;
        push(3, 0);
        @(posedge clock);
        #1;
        repeat (24) begin @(posedge clock); #1; end
        pulses(3);
        wait_result("after_sat", 36, 121, 1'b1);
        drop2("after_sat");

        // Asynchronous reset in the middle of COUNT.
        @(negedge clock);
        period = 10;
        en     = 1'b1;
        @(posedge clock);
        repeat (30) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_done", 32'(done), 0);
        check("async_rst_freq", 32'(freq), 0);
        check("async_rst_ovf", 32'(ovf), 0);
        check("async_rst_freq2", 32'(freq2), 0);
        @(negedge clock);
        en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        measure("post_reset", 10, 10);

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
